imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor of the combinational immediate generator in the decode stage. Accepts an instruction, its PC, an immediate-select code and a sideband tag over a valid/ready handshake. Emits the sign-/zero-extended XLEN-wide immediate and the PC-relative target (pc + imm) from a registered output stage. Includes a skid buffer so in_ready is a registered signal and full throughput is sustained under backpressure.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 (elaboration assertion otherwise).
TAG_W, 4, width of the opaque sideband tag passed through unchanged.

Ports:
clk  input  1  clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream request valid.
in_ready  output  1  upstream may transfer; registered.
in_instr  input  32  raw instruction word.
in_pc  input  XLEN  PC of in_instr.
in_sel  input  4  immediate select (imm_sel_e).
in_tag  input  TAG_W  sideband, passed through.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts.
out_imm  output  XLEN  extended immediate.
out_target  output  XLEN  out_pc + out_imm, modulo 2^XLEN.
out_pc  output  XLEN  PC of the result.
out_tag  output  TAG_W  tag of the result.
out_err  output  1  in_sel was not a legal code; out_imm = 0.

Behaviour:
- Select codes: 0001 I {sext instr[31:20]}; 0010 U {sext instr[31:12], 12'b0} (sign-extend to 64 when XLEN=64); 0011 S {sext instr[31:25], instr[11:7]}; 0100 B {sext instr[31], instr[7], instr[30:25], instr[11:8], 0}; 0101 J {sext instr[31], instr[19:12], instr[20], instr[30:21], 0}; 0110 SHAMT zext instr[24:20] (XLEN=32) / instr[25:20] (XLEN=64); 0111 ZIMM zext instr[19:15].
- Any other code (incl. 0000): imm = 0, err = 1. No latches; decoder fully assigned on every path.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Latency: 1 cycle from input transfer to out_valid when the output stage is empty or draining.
- Output stage loads when (!out_valid || out_ready): from skid entry if skid valid, else from input if in_valid, else out_valid deasserts.
- Skid captures the input when an input transfer occurs while the output stage is valid and !out_ready. in_ready next = !skid_valid_next. At most one skid entry; no drops, no duplicates, strict order.
- Simultaneous skid drain and new input: skid moves to output; input is accepted only if in_ready was 1 (it goes into skid).
- out_* data held stable while out_valid && !out_ready.
- Target add wraps silently, no overflow flag.
- Reset (asynchronous, any cycle incl. mid-stall): out_valid=0, skid_valid=0, in_ready=1, out_imm/out_target/out_pc=0, out_tag=0, out_err=0; in-flight entries discarded.

Decomposition:
- imm_gen_pkg: imm_sel_e enum (IMM_I, IMM_U, IMM_S, IMM_B, IMM_J, IMM_SHAMT, IMM_ZIMM) with the 4-bit codes above; a packed struct imm_req_t {instr, pc, sel, tag} for skid and output registers.
- Sub-module imm_decode (combinational, XLEN param): instr + sel -> imm, err. imm_gen_pipe wraps it with skid, output register and adder.

Test Plan:
- I: instr 0xFFF00093, sel 0001, pc 0x100, out_ready=1 -> next cycle out_imm 0xFFFFFFFF, out_target 0x000000FF, err 0.
- U/S: 0x12345037 sel 0010 -> 0x12345000; 0xFE112E23 sel 0011 -> 0xFFFFFFFC; back-to-back, one result per cycle, order preserved.
- B wrap: 0xFE000CE3 sel 0100, pc 0x4 -> imm 0xFFFFFFF8, target 0xFFFFFFFC; XLEN=64 -> imm 0xFFFFFFFFFFFFFFF8.
- Illegal: sel 1111 any instr -> out_imm 0, out_err 1, tag echoed; following legal request has err 0.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 accepted, in_ready 0 from cycle 2, out_* stable; release -> both delivered in order, in_ready back to 1.
- Reset mid-stall: assert rst_n=0 with out_valid and skid full -> all outputs 0 and in_ready 1 immediately; no stale result after release.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined immediate generator: select codes and the
// small helpers used by the decoder and the request/response interface.
package imm_gen_pkg;

  localparam int INSTR_W = 32;
  localparam int SEL_W   = 4;

  typedef enum logic [SEL_W-1:0] {
    IMM_I     = 4'b0001,
    IMM_U     = 4'b0010,
    IMM_S     = 4'b0011,
    IMM_B     = 4'b0100,
    IMM_J     = 4'b0101,
    IMM_SHAMT = 4'b0110,
    IMM_ZIMM  = 4'b0111
  } imm_sel_e;

  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return sel inside {IMM_I, IMM_U, IMM_S, IMM_B, IMM_J, IMM_SHAMT, IMM_ZIMM};
  endfunction

endpackage

// File: rtl/imm_gen_if.sv
// Request/response channel of the immediate generator: a valid/ready input
// side carrying the instruction and a valid/ready output side carrying results.
interface imm_gen_if
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [XLEN-1:0]    in_pc;
  logic [SEL_W-1:0]   in_sel;
  logic [TAG_W-1:0]   in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_imm;
  logic [XLEN-1:0]    out_target;
  logic [XLEN-1:0]    out_pc;
  logic [TAG_W-1:0]   out_tag;
  logic               out_err;

  modport master (
    output in_valid, in_instr, in_pc, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_target, out_pc, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_target, out_pc, out_tag, out_err
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extraction: instruction word + select code ->
// XLEN-wide sign/zero-extended immediate and an illegal-select flag.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [SEL_W-1:0]   sel,
  output logic [XLEN-1:0]    imm,
  output logic               err
);

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
    imm = '0;
    err = !sel_legal(sel);
    case (sel)
      IMM_I:     imm = XLEN'($signed(instr[31:20]));
      IMM_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_SHAMT: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      IMM_ZIMM:  imm = XLEN'(instr[19:15]);
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one-entry skid buffer in front of a registered
// output stage holding imm, pc + imm, pc, tag and the illegal-select flag.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  imm_gen_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64, got %0d", XLEN);
  end

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic [SEL_W-1:0]   sel;
    logic [TAG_W-1:0]   tag;
  } imm_req_t;

  imm_req_t        in_req;
  imm_req_t        skid_q;
  imm_req_t        src;
  logic            skid_valid;
  logic            skid_valid_next;
  logic            skid_wr;
  logic            in_fire;
  logic            load_out;
  logic [XLEN-1:0] src_imm;
  logic            src_err;

  always_comb begin
    in_req   = '{instr: bus.in_instr, pc: bus.in_pc, sel: bus.in_sel, tag: bus.in_tag};
    in_fire  = bus.in_valid && bus.in_ready;
    load_out = !bus.out_valid || bus.out_ready;
    // The skid entry is always older than anything on the input, so it goes first.
    src      = skid_valid ? skid_q : in_req;
    skid_wr  = in_fire && (skid_valid || !load_out);
    skid_valid_next = skid_wr || (skid_valid && !load_out);
  end

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr (src.instr),
    .sel   (src.sel),
    .imm   (src_imm),
    .err   (src_err)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid     <= 1'b0;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.out_imm    <= '0;
      bus.out_target <= '0;
      bus.out_pc     <= '0;
      bus.out_tag    <= '0;
      bus.out_err    <= 1'b0;
    end else begin
      skid_valid   <= skid_valid_next;
      bus.in_ready <= !skid_valid_next;
      if (load_out) begin
        bus.out_valid <= skid_valid || in_fire;
        if (skid_valid || in_fire) begin
          bus.out_imm    <= src_imm;
          bus.out_target <= src.pc + src_imm;
          bus.out_pc     <= src.pc;
          bus.out_tag    <= src.tag;
          bus.out_err    <= src_err;
        end
      end
    end
  end

  // NOTE: skid payload is not reset; skid_valid alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (skid_wr) begin
      skid_q <= in_req;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe: decode of every select code,
// back-to-back streaming, backpressure through the skid buffer and mid-stall reset.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_gen_if #(.XLEN(32), .TAG_W(4)) bus ();
  imm_gen_if #(.XLEN(64), .TAG_W(4)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [3:0] sel, input logic [3:0] tag);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.in_sel   = sel;
    bus.in_tag   = tag;
  endtask

  task automatic drive64(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                         input logic [3:0] sel, input logic [3:0] tag);
    bus64.in_valid = v;
    bus64.in_instr = instr;
    bus64.in_pc    = pc;
    bus64.in_sel   = sel;
    bus64.in_tag   = tag;
  endtask

  task automatic check_out(input string tag, input logic [31:0] imm, input logic [31:0] target,
                           input logic [31:0] pc, input logic [3:0] t, input logic err);
    check({tag, ".valid"},  bus.out_valid, 1);
    check({tag, ".imm"},    bus.out_imm, imm);
    check({tag, ".target"}, bus.out_target, target);
    check({tag, ".pc"},     bus.out_pc, pc);
    check({tag, ".tag"},    bus.out_tag, t);
    check({tag, ".err"},    bus.out_err, err);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"},    bus.out_valid, 0);
    check({tag, ".in_ready"}, bus.in_ready, 1);
    check({tag, ".imm"},      bus.out_imm, 0);
    check({tag, ".target"},   bus.out_target, 0);
    check({tag, ".pc"},       bus.out_pc, 0);
    check({tag, ".tag"},      bus.out_tag, 0);
    check({tag, ".err"},      bus.out_err, 0);
  endtask

  // Backpressure vectors: I imm 5, S imm -4, U imm 0x12345000.
  logic [31:0] v_instr [3];
  logic [31:0] v_pc    [3];
  logic [3:0]  v_sel   [3];
  logic [3:0]  v_tag   [3];

  initial begin
    int  k;
    logic acc;

    v_instr[0] = 32'h00500093; v_pc[0] = 32'h1000; v_sel[0] = 4'b0001; v_tag[0] = 4'h1;
    v_instr[1] = 32'hFE112E23; v_pc[1] = 32'h2000; v_sel[1] = 4'b0011; v_tag[1] = 4'h2;
    v_instr[2] = 32'h12345037; v_pc[2] = 32'h0000; v_sel[2] = 4'b0010; v_tag[2] = 4'h3;

    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    drive64(1'b0, '0, '0, '0, '0);
    bus.out_ready   = 1'b0;
    bus64.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // I-type: -1 added to 0x100.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 32'h100, 4'b0001, 4'h3);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_out("i", 32'hFFFFFFFF, 32'h000000FF, 32'h100, 4'h3, 1'b0);

    // U then S back-to-back, one result per cycle.
    @(posedge clk); #1;
    drive(1'b1, 32'h12345037, 32'h200, 4'b0010, 4'h4);
    @(posedge clk); #1;
    drive(1'b1, 32'hFE112E23, 32'h300, 4'b0011, 4'h5);
    @(negedge clk);
    check_out("u", 32'h12345000, 32'h12345200, 32'h200, 4'h4, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_out("s", 32'hFFFFFFFC, 32'h000002FC, 32'h300, 4'h5, 1'b0);

    // B-type: target wraps below zero.
    @(posedge clk); #1;
    drive(1'b1, 32'hFE000CE3, 32'h4, 4'b0100, 4'h6);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_out("b", 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h4, 4'h6, 1'b0);

    // Illegal select, then J, then sel 0000, then SHAMT and ZIMM streaming.
    @(posedge clk); #1;
    drive(1'b1, 32'hDEADBEEF, 32'h500, 4'b1111, 4'hA);
    @(posedge clk); #1;
    drive(1'b1, 32'h0080006F, 32'h600, 4'b0101, 4'hB);
    @(negedge clk);
    check_out("illegal", 32'h0, 32'h500, 32'h500, 4'hA, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 32'hFFFFFFFF, 32'h700, 4'b0000, 4'hC);
    @(negedge clk);
    check_out("j", 32'h8, 32'h608, 32'h600, 4'hB, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 32'h03F0D093, 32'h0, 4'b0110, 4'hD);
    @(negedge clk);
    check_out("sel0", 32'h0, 32'h700, 32'h700, 4'hC, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 32'h000F8073, 32'h10, 4'b0111, 4'hE);
    @(negedge clk);
    check_out("shamt32", 32'd31, 32'd31, 32'h0, 4'hD, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_out("zimm", 32'd31, 32'h2F, 32'h10, 4'hE, 1'b0);
    @(negedge clk);
    check("drain.valid", bus.out_valid, 0);

    // Backpressure: five stalled cycles with a source that always has data.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    k = 0;
    drive(1'b1, v_instr[0], v_pc[0], v_sel[0], v_tag[0]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      check("bp.in_ready", bus.in_ready, (c < 2) ? 64'd1 : 64'd0);
      if (c >= 1) begin
        check("bp.hold.valid", bus.out_valid, 1);
        check("bp.hold.imm", bus.out_imm, 32'd5);
        check("bp.hold.target", bus.out_target, 32'h1005);
        check("bp.hold.tag", bus.out_tag, 4'h1);
      end
      @(posedge clk); #1;
      if (acc) begin
        k++;
        drive(1'b1, v_instr[k], v_pc[k], v_sel[k], v_tag[k]);
      end
    end
    check("bp.accepted", k, 2);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_out("bp.first", 32'd5, 32'h1005, 32'h1000, 4'h1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_out("bp.second", 32'hFFFFFFFC, 32'h1FFC, 32'h2000, 4'h2, 1'b0);
    check("bp.ready_back", bus.in_ready, 1);
    @(negedge clk);
    check("bp.empty", bus.out_valid, 0);

    // Reset asserted with the output stage and skid both full.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive(1'b1, v_instr[0], v_pc[0], v_sel[0], v_tag[0]);
    @(posedge clk); #1;
    drive(1'b1, v_instr[1], v_pc[1], v_sel[1], v_tag[1]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst.pre.valid", bus.out_valid, 1);
    check("rst.pre.in_ready", bus.in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("rst.async");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst.post.valid", bus.out_valid, 0);
      check("rst.post.in_ready", bus.in_ready, 1);
    end

    // XLEN = 64: sign extension reaches bit 63, SHAMT uses six bits.
    @(posedge clk); #1;
    drive64(1'b1, 32'hFE000CE3, 64'h4, 4'b0100, 4'h1);
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    @(negedge clk);
    check("x64.b.valid", bus64.out_valid, 1);
    check("x64.b.imm", bus64.out_imm, 64'hFFFFFFFFFFFFFFF8);
    check("x64.b.target", bus64.out_target, 64'hFFFFFFFFFFFFFFFC);
    @(posedge clk); #1;
    drive64(1'b1, 32'h03F0D093, 64'h0, 4'b0110, 4'h2);
    @(posedge clk); #1;
    drive64(1'b1, 32'h80000037, 64'h1000, 4'b0010, 4'h3);
    @(negedge clk);
    check("x64.shamt.imm", bus64.out_imm, 64'd63);
    check("x64.shamt.tag", bus64.out_tag, 4'h2);
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    @(negedge clk);
    check("x64.u.imm", bus64.out_imm, 64'hFFFFFFFF80000000);
    check("x64.u.target", bus64.out_target, 64'hFFFFFFFF80001000);
    check("x64.u.err", bus64.out_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
